// File: rtl/regfile_pkg.sv
// Shared defaults and derived constants for the register file and its scoreboard.
package regfile_pkg;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned CNT_W_DEF  = 2;
  localparam int unsigned NREGS      = 2**ADDR_W_DEF;
  localparam int unsigned CNT_MAX    = 2**CNT_W_DEF - 1;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write counters, RAW/overflow stall, sticky ERR and PENDING_ANY.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] AA,
  input  logic [ADDR_W-1:0] BA,
  input  logic              ISSUE_VALID,
  input  logic              A_USE,
  input  logic              B_USE,
  input  logic              ISSUE_RW,
  input  logic [ADDR_W-1:0] ISSUE_DA,
  input  logic              WB_RW,
  input  logic [ADDR_W-1:0] WB_DA,
  output logic              STALL,
  output logic              PENDING_ANY,
  output logic              ERR
);
  localparam int unsigned N = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CNT_TOP = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic err_q, err_d;
  logic pend_q, pend_d;
  logic rdy_a, rdy_b, full_da, accept, inc_en, dec_en;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // A register with a single pending write that retires this cycle is ready via the bypass.
  assign rdy_a = is_zero(AA) || (cnt_q[AA] == '0) ||
                 ((cnt_q[AA] == CNT_ONE) && WB_RW && (WB_DA == AA));
  assign rdy_b = is_zero(BA) || (cnt_q[BA] == '0) ||
                 ((cnt_q[BA] == CNT_ONE) && WB_RW && (WB_DA == BA));
  assign full_da = ISSUE_RW && (cnt_q[ISSUE_DA] == CNT_TOP) &&
                   !(WB_RW && (WB_DA == ISSUE_DA));

  // Qualifiers gate each term first so unused addresses cannot influence STALL.
  assign STALL  = ISSUE_VALID && ((A_USE && !rdy_a) || (B_USE && !rdy_b) || full_da);
  assign accept = ISSUE_VALID && !STALL;
  assign inc_en = accept && ISSUE_RW && !is_zero(ISSUE_DA);
  assign dec_en = WB_RW && !is_zero(WB_DA);

  // Next counter values: issue increments, retire decrements, both together cancel.
  always_comb begin
    err_d  = err_q;
    pend_d = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      logic inc, dec;
      inc      = inc_en && (ISSUE_DA == ADDR_W'(i));
      dec      = dec_en && (WB_DA == ADDR_W'(i));
      cnt_d[i] = cnt_q[i];
      if (dec && (cnt_q[i] == '0)) err_d = 1'b1;
      if (inc && !dec)
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      else if (dec && !inc && (cnt_q[i] != '0))
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      pend_d = pend_d | (cnt_d[i] != '0);
    end
  end

  // Scoreboard state register; reset overrides issue and retire.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
      err_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      err_q  <= err_d;
      pend_q <= pend_d;
    end
  end

  assign PENDING_ANY = pend_q;
  assign ERR         = err_q;
endmodule

// File: rtl/regfile_sb.sv
// Register file with write-back bypass and a pending-write scoreboard driving issue stalls.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] AA,
  input  logic [ADDR_W-1:0] BA,
  output logic [DATA_W-1:0] A_DATA,
  output logic [DATA_W-1:0] B_DATA,
  input  logic              ISSUE_VALID,
  input  logic              A_USE,
  input  logic              B_USE,
  input  logic              ISSUE_RW,
  input  logic [ADDR_W-1:0] ISSUE_DA,
  output logic              STALL,
  input  logic              WB_RW,
  input  logic [ADDR_W-1:0] WB_DA,
  input  logic [DATA_W-1:0] WB_DATA,
  output logic              PENDING_ANY,
  output logic              ERR
);
  localparam int unsigned N = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [N];
  logic              wr_en;

  assign wr_en = WB_RW && !((ZERO_REG != 0) && (WB_DA == '0));

  // Register storage; writes to the hardwired zero register are dropped.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < N; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[WB_DA] <= WB_DATA;
    end
  end

  assign A_DATA = ((ZERO_REG != 0) && (AA == '0)) ? '0 :
                  (WB_RW && (WB_DA == AA))        ? WB_DATA : regs_q[AA];
  assign B_DATA = ((ZERO_REG != 0) && (BA == '0)) ? '0 :
                  (WB_RW && (WB_DA == BA))        ? WB_DATA : regs_q[BA];

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .CNT_W    (CNT_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .AA          (AA),
    .BA          (BA),
    .ISSUE_VALID (ISSUE_VALID),
    .A_USE       (A_USE),
    .B_USE       (B_USE),
    .ISSUE_RW    (ISSUE_RW),
    .ISSUE_DA    (ISSUE_DA),
    .WB_RW       (WB_RW),
    .WB_DA       (WB_DA),
    .STALL       (STALL),
    .PENDING_ANY (PENDING_ANY),
    .ERR         (ERR)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomized bench for regfile_sb against a behavioural model.
module tb_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int CMAX = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] aa, ba, issue_da, wb_da;
  logic [DW-1:0] a_data, b_data, wb_data;
  logic          issue_valid, a_use, b_use, issue_rw, wb_rw;
  logic          stall, pending_any, err;

  int n_cmp = 0;
  int n_err = 0;

  int unsigned   m_cnt [NR];
  logic [DW-1:0] m_reg [NR];
  bit            m_err, m_pend;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .CNT_W(2)) dut (
    .CLOCK(clk), .RESET(rst), .AA(aa), .BA(ba), .A_DATA(a_data), .B_DATA(b_data),
    .ISSUE_VALID(issue_valid), .A_USE(a_use), .B_USE(b_use), .ISSUE_RW(issue_rw),
    .ISSUE_DA(issue_da), .STALL(stall), .WB_RW(wb_rw), .WB_DA(wb_da),
    .WB_DATA(wb_data), .PENDING_ANY(pending_any), .ERR(err)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_read(input int unsigned a);
    if (a == 0) return '0;
    if (wb_rw && int'(wb_da) == a) return wb_data;
    return m_reg[a];
  endfunction

  function automatic bit m_rdy(input int unsigned x);
    return (x == 0) || (m_cnt[x] == 0) || (m_cnt[x] == 1 && wb_rw && int'(wb_da) == x);
  endfunction

  function automatic bit m_stall();
    bit ovf;
    if (!issue_valid) return 1'b0;
    ovf = issue_rw && issue_da != 0 && m_cnt[issue_da] == CMAX && !(wb_rw && wb_da == issue_da);
    return (a_use && !m_rdy(aa)) || (b_use && !m_rdy(ba)) || ovf;
  endfunction

  task automatic m_update(input bit stalled);
    bit incr, decr;
    if (rst) begin
      for (int i = 0; i < NR; i++) begin m_cnt[i] = 0; m_reg[i] = '0; end
      m_err = 0;
    end else begin
      incr = issue_valid && !stalled && issue_rw && issue_da != 0;
      decr = wb_rw && wb_da != 0;
      if (decr && m_cnt[wb_da] == 0) m_err = 1;
      if (!(incr && decr && issue_da == wb_da)) begin
        if (decr && m_cnt[wb_da] > 0) m_cnt[wb_da] = m_cnt[wb_da] - 1;
        if (incr) m_cnt[issue_da] = m_cnt[issue_da] + 1;
      end
      if (decr) m_reg[wb_da] = wb_data;
    end
    m_pend = 0;
    for (int i = 0; i < NR; i++) if (m_cnt[i] != 0) m_pend = 1;
  endtask

  // One clock: compare against the model mid-cycle, then advance the model at the edge.
  task automatic cyc();
    logic [DW-1:0] ea, eb;
    bit es;
    #1;
    ea = m_read(aa);
    eb = m_read(ba);
    es = m_stall();
    check("A_DATA", a_data, ea);
    check("B_DATA", b_data, eb);
    check("STALL", 32'(stall), 32'(es));
    check("PENDING_ANY", 32'(pending_any), 32'(m_pend));
    check("ERR", 32'(err), 32'(m_err));
    @(posedge clk);
    m_update(es);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; aa = '0; ba = '0; issue_valid = 0; a_use = 0; b_use = 0;
    issue_rw = 0; issue_da = '0; wb_rw = 0; wb_da = '0; wb_data = '0;
  endtask

  task automatic issue_wr(input int unsigned d);
    idle(); issue_valid = 1; issue_rw = 1; issue_da = AW'(d);
  endtask

  task automatic retire(input int unsigned d, input logic [DW-1:0] v);
    idle(); wb_rw = 1; wb_da = AW'(d); wb_data = v;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    m_update(1'b0);
    idle();

    // Reset state: every address reads zero on both ports.
    for (int i = 0; i < NR; i++) begin
      aa = AW'(i); ba = AW'(NR - 1 - i);
      cyc();
    end
    check("reset_pending", 32'(pending_any), 32'd0);
    check("reset_err", 32'(err), 32'd0);

    // Write R5 then read it back next cycle.
    issue_wr(5); cyc();
    retire(5, 32'hDEADBEEF); cyc();
    idle(); aa = 5; #1; check("r5_read", a_data, 32'hDEADBEEF); cyc();

    // Same-cycle bypass on R7.
    issue_wr(7); cyc();
    retire(7, 32'h12345678); aa = 7; #1; check("bypass_r7", a_data, 32'h12345678); cyc();
    retire(0, 32'hFFFFFFFF); cyc();
    idle(); aa = 0; ba = 0; #1; check("r0_zero", a_data, 32'd0); cyc();
    check("no_err_r0", 32'(err), 32'd0);

    // RAW hazard on R3 resolved by a retire in the same cycle.
    issue_wr(3); cyc();
    idle(); issue_valid = 1; a_use = 1; aa = 3; #1; check("raw_stall", 32'(stall), 32'd1); cyc();
    cyc();
    wb_rw = 1; wb_da = 3; wb_data = 32'hCAFE0003;
    #1; check("raw_release", 32'(stall), 32'd0); check("raw_bypass", a_data, 32'hCAFE0003); cyc();

    // Overflow guard on R9.
    for (int i = 0; i < 3; i++) begin issue_wr(9); cyc(); end
    check("pend_r9", 32'(pending_any), 32'd1);
    issue_wr(9); #1; check("ovf_stall", 32'(stall), 32'd1); cyc();
    wb_rw = 1; wb_da = 9; wb_data = 32'h99; #1; check("ovf_release", 32'(stall), 32'd0); cyc();
    issue_wr(9); #1; check("ovf_still_full", 32'(stall), 32'd1); cyc();
    for (int i = 0; i < 3; i++) begin retire(9, DW'(i)); cyc(); end
    idle(); #1; check("drained", 32'(pending_any), 32'd0); cyc();

    // Retire with nothing pending sets a sticky error.
    check("err_before", 32'(err), 32'd0);
    retire(4, 32'h44); cyc();
    idle(); issue_valid = 1; a_use = 1; aa = 4;
    #1; check("err_set", 32'(err), 32'd1); check("r4_ready", 32'(stall), 32'd0); cyc();
    idle(); cyc(); cyc();
    check("err_sticky", 32'(err), 32'd1);

    // Reset wins over a pending issue.
    issue_wr(3); cyc();
    issue_wr(3); cyc();
    issue_wr(3); rst = 1; cyc();
    idle(); issue_valid = 1; a_use = 1; aa = 3;
    #1;
    check("rst_pending", 32'(pending_any), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_r3", a_data, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    cyc();

    // Randomized traffic over a narrow address window to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      int unsigned r;
      idle();
      rst         = ($urandom_range(0, 149) == 0);
      issue_valid = $urandom_range(0, 1) == 1;
      a_use       = $urandom_range(0, 1) == 1;
      b_use       = $urandom_range(0, 1) == 1;
      issue_rw    = $urandom_range(0, 2) != 0;
      issue_da    = AW'($urandom_range(0, 7));
      aa          = AW'($urandom_range(0, 7));
      ba          = AW'($urandom_range(0, 7));
      r           = $urandom_range(0, 7);
      wb_rw       = (m_cnt[r] != 0 && $urandom_range(0, 2) != 0) || ($urandom_range(0, 39) == 0);
      wb_da       = AW'(r);
      wb_data     = $urandom;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
